// File: rtl/vme_dpi_pkg.sv
// Shared types and constants for the VME-to-DPI memory-model adapter.
// Holds the adapter FSM state encoding and the request opcode values.
package vme_dpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WR   = 3'd2,
        ST_RD   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic OPC_RD = 1'b0;
    localparam logic OPC_WR = 1'b1;

    localparam int unsigned STAT_BITS = 32;

endpackage

// File: rtl/vme_rd_fifo.sv
// Read-return buffer between the memory model and the rdata port.
// Ports:
//   clock, reset            - clock, synchronous active-high reset (flushes)
//   push_i, push_data_i     - write one entry
//   pop_i                   - remove the head entry
//   pop_data_o              - head entry (push data passes through when empty)
//   full_o, empty_o         - occupancy flags
// Push+pop together leaves the occupancy unchanged, including at full and
// at empty (the empty case is a pass-through and stores nothing).
module vme_rd_fifo
    import vme_dpi_pkg::*;
#(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // A pop on empty consumes the incoming word directly, so nothing is stored.
    assign wr_en = push_i && (!full_o || pop_i) && !(empty_o && pop_i);
    assign rd_en = pop_i && !empty_o;

    assign pop_data_o = empty_o ? push_data_i : mem_q[rd_ptr_q];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    // Storage array, no reset needed: occupancy gates every read.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/vme_dpi_adapter.sv
// Adapter from a burst command/data interface to a DPI memory model.
// Optional macro: VME_DPI_ADAPTER_STATS_EN adds stat_rd_beats/stat_wr_beats.
// Ports:
//   clock, reset                      - clock, synchronous active-high reset
//   cmd_*                             - burst command (write flag, addr, beats-1)
//   wdata_*                           - write beats in, forwarded to dpi_wr_*
//   rdata_*                           - read beats out of the read buffer
//   done, err                         - completion pulse, sticky wdata_last error
//   dpi_req_*                         - one-cycle request to the memory model
//   dpi_wr_valid/bits                 - write beats to the memory model
//   dpi_rd_valid/bits/ready           - read beats from the memory model
//   stat_rd_beats, stat_wr_beats      - DPI beat counters (stats build only)
module vme_dpi_adapter
    import vme_dpi_pkg::*;
#(
    parameter int unsigned LEN_BITS  = 8,
    parameter int unsigned ADDR_BITS = 64,
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned RD_DEPTH  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef VME_DPI_ADAPTER_STATS_EN
    output logic [STAT_BITS-1:0] stat_rd_beats,
    output logic [STAT_BITS-1:0] stat_wr_beats,
`endif
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [LEN_BITS-1:0]  cmd_len,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    input  logic [DATA_BITS-1:0] wdata_bits,
    input  logic                 wdata_last,
    output logic                 rdata_valid,
    input  logic                 rdata_ready,
    output logic [DATA_BITS-1:0] rdata_bits,
    output logic                 rdata_last,
    output logic                 done,
    output logic                 err,
    output logic                 dpi_req_valid,
    output logic                 dpi_req_opcode,
    output logic [LEN_BITS-1:0]  dpi_req_len,
    output logic [ADDR_BITS-1:0] dpi_req_addr,
    output logic                 dpi_wr_valid,
    output logic [DATA_BITS-1:0] dpi_wr_bits,
    input  logic                 dpi_rd_valid,
    input  logic [DATA_BITS-1:0] dpi_rd_bits,
    output logic                 dpi_rd_ready
);

    // One extra bit so len = all-ones counts 2^LEN_BITS beats without wrapping.
    localparam int unsigned CNT_W  = LEN_BITS + 1;
    localparam int unsigned FIFO_W = DATA_BITS + 1;

    state_e                 state_q, state_d;
    logic                   write_q, write_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [LEN_BITS-1:0]    len_q, len_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic                   err_q, err_d;

    logic                   beat_is_last;
    logic                   wr_hs;
    logic                   rd_push;
    logic                   rd_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_W-1:0]      fifo_head;

    assign beat_is_last = (beat_q == {1'b0, len_q});
    assign wr_hs        = wdata_valid && wdata_ready;
    assign rd_push      = dpi_rd_valid && dpi_rd_ready;
    assign rd_pop       = rdata_valid && rdata_ready;

    // Each buffered beat carries its own last flag next to the data.
    vme_rd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (RD_DEPTH)
    ) u_rd_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (rd_push),
        .push_data_i ({beat_is_last, dpi_rd_bits}),
        .pop_i       (rd_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rdata_valid    = !fifo_empty;
    assign rdata_bits     = fifo_head[DATA_BITS-1:0];
    assign rdata_last     = fifo_head[DATA_BITS];
    assign err            = err_q;
    assign dpi_req_opcode = write_q ? OPC_WR : OPC_RD;
    assign dpi_req_len    = len_q;
    assign dpi_req_addr   = addr_q;

    // State and command/beat registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    beat_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = write_q ? ST_WR : ST_RD;
            end
            ST_WR: begin
                if (wr_hs) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (wdata_last != beat_is_last) err_d = 1'b1;
                    if (beat_is_last) state_d = ST_DONE;
                end
            end
            ST_RD: begin
                if (rd_push) beat_d = beat_q + CNT_W'(1);
                if (rd_pop && rdata_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; DPI-facing strobes are held off while in reset.
    always_comb begin
        cmd_ready     = 1'b0;
        dpi_req_valid = 1'b0;
        wdata_ready   = 1'b0;
        dpi_wr_valid  = 1'b0;
        dpi_wr_bits   = '0;
        dpi_rd_ready  = 1'b0;
        done          = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_REQ:  dpi_req_valid = !reset;
            ST_WR: begin
                wdata_ready  = !reset;
                dpi_wr_valid = wdata_valid && !reset;
                dpi_wr_bits  = reset ? '0 : wdata_bits;
            end
            ST_RD:   dpi_rd_ready = !fifo_full && !reset;
            ST_DONE: done = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

`ifdef VME_DPI_ADAPTER_STATS_EN
    logic [STAT_BITS-1:0] stat_rd_q, stat_rd_d;
    logic [STAT_BITS-1:0] stat_wr_q, stat_wr_d;

    // Free-running DPI beat counters, wrapping naturally.
    always_comb begin
        stat_rd_d = stat_rd_q + STAT_BITS'(rd_push);
        stat_wr_d = stat_wr_q + STAT_BITS'(dpi_wr_valid);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            stat_rd_q <= stat_rd_d;
            stat_wr_q <= stat_wr_d;
        end
    end

    assign stat_rd_beats = stat_rd_q;
    assign stat_wr_beats = stat_wr_q;
`endif

endmodule

// File: tb/tb_vme_dpi_adapter.sv
// Self-checking bench for vme_dpi_adapter: a memory model that serves beat i
// of a burst as a function of (addr, salt, i), plus a write-data source and a
// read-data sink, all driven with random valid/ready gaps.
module tb_vme_dpi_adapter;

    localparam int unsigned LB = 8;
    localparam int unsigned AB = 64;
    localparam int unsigned DB = 64;
    localparam int BUDGET = 4000;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AB-1:0] cmd_addr;
    logic [LB-1:0] cmd_len;
    logic          wdata_valid, wdata_ready, wdata_last;
    logic [DB-1:0] wdata_bits;
    logic          rdata_valid, rdata_ready, rdata_last;
    logic [DB-1:0] rdata_bits;
    logic          done, err;
    logic          dpi_req_valid, dpi_req_opcode;
    logic [LB-1:0] dpi_req_len;
    logic [AB-1:0] dpi_req_addr;
    logic          dpi_wr_valid;
    logic [DB-1:0] dpi_wr_bits;
    logic          dpi_rd_valid, dpi_rd_ready;
    logic [DB-1:0] dpi_rd_bits;
`ifdef VME_DPI_ADAPTER_STATS_EN
    logic [31:0]   stat_rd_beats, stat_wr_beats;
`endif

    vme_dpi_adapter #(.LEN_BITS(LB), .ADDR_BITS(AB), .DATA_BITS(DB), .RD_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
`ifdef VME_DPI_ADAPTER_STATS_EN
        .stat_rd_beats(stat_rd_beats), .stat_wr_beats(stat_wr_beats),
`endif
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata_bits(wdata_bits), .wdata_last(wdata_last),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .rdata_bits(rdata_bits), .rdata_last(rdata_last),
        .done(done), .err(err),
        .dpi_req_valid(dpi_req_valid), .dpi_req_opcode(dpi_req_opcode),
        .dpi_req_len(dpi_req_len), .dpi_req_addr(dpi_req_addr),
        .dpi_wr_valid(dpi_wr_valid), .dpi_wr_bits(dpi_wr_bits),
        .dpi_rd_valid(dpi_rd_valid), .dpi_rd_bits(dpi_rd_bits),
        .dpi_rd_ready(dpi_rd_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction context shared by the stimulus driver and the runner.
    bit            x_wr;
    logic [AB-1:0] x_addr;
    logic [31:0]   x_salt;
    int            x_len, x_hold, x_err_beat, x_cyc, x_wr_idx, x_mem_idx;
    int unsigned   x_wpct, x_dpct, x_rpct;

    // Observations of the last transaction.
    int          ob_req_pulses, ob_wr_hs, ob_wr_bad, ob_rd_pops, ob_rd_bad, ob_last_cnt;
    int          ob_accept_cycle, ob_last_wr_cycle, ob_last_pop_cycle, ob_done_cycle;
    int          ob_done_cycles, ob_stall_push;
    logic        ob_stall_ready, ob_post_ready, ob_req_opc;
    logic [LB-1:0] ob_req_len;
    logic [AB-1:0] ob_req_addr;
    bit          ob_timeout;

    function automatic logic [63:0] mdata(input logic [63:0] a, input logic [31:0] s, input int i);
        logic [63:0] iv;
        iv = 64'(unsigned'(i));
        return a ^ {s, iv[31:0]} ^ (iv * 64'h9E37_79B9_7F4A_7C15);
    endfunction

    task automatic drive_idle();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata_bits = '0; wdata_last = 1'b0;
        rdata_ready = 1'b0; dpi_rd_valid = 1'b0; dpi_rd_bits = '0;
    endtask

    task automatic drive_step();
        wdata_valid  = 1'b0;
        dpi_rd_valid = 1'b0;
        if (x_wr && x_wr_idx <= x_len) begin
            wdata_valid = ($urandom_range(99) < x_wpct);
            wdata_bits  = mdata(x_addr, x_salt, x_wr_idx);
            wdata_last  = (x_wr_idx == x_len) ^ (x_wr_idx == x_err_beat);
        end
        if (!x_wr && x_mem_idx <= x_len) begin
            dpi_rd_valid = ($urandom_range(99) < x_dpct);
            dpi_rd_bits  = mdata(x_addr, x_salt, x_mem_idx);
        end
        rdata_ready = (x_cyc < x_hold) ? 1'b0 : ($urandom_range(99) < x_rpct);
    endtask

    // Runs one command to completion; called just after a rising edge.
    task automatic do_xfer(input bit wr, input logic [AB-1:0] addr, input int len,
                           input int unsigned wpct, input int unsigned dpct,
                           input int unsigned rpct, input int hold, input int err_beat);
        bit accepted, done_seen, fin, hs;
        x_wr = wr; x_addr = addr; x_len = len; x_salt = $urandom;
        x_wpct = wpct; x_dpct = dpct; x_rpct = rpct; x_hold = hold; x_err_beat = err_beat;
        x_cyc = 0; x_wr_idx = 0; x_mem_idx = 0;
        ob_req_pulses = 0; ob_wr_hs = 0; ob_wr_bad = 0; ob_rd_pops = 0; ob_rd_bad = 0;
        ob_last_cnt = 0; ob_accept_cycle = -1; ob_last_wr_cycle = -1; ob_last_pop_cycle = -1;
        ob_done_cycle = -1; ob_done_cycles = 0; ob_stall_push = -1; ob_stall_ready = 1'bx;
        ob_post_ready = 1'b0; ob_req_opc = 1'bx; ob_req_len = 'x; ob_req_addr = 'x; ob_timeout = 0;
        accepted = 0; done_seen = 0; fin = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = LB'(len);
        drive_step();
        while (!fin) begin
            @(negedge clock);
            if (cmd_valid && cmd_ready && !accepted) begin accepted = 1; ob_accept_cycle = x_cyc; end
            if (dpi_req_valid) begin
                ob_req_pulses++; ob_req_opc = dpi_req_opcode; ob_req_len = dpi_req_len; ob_req_addr = dpi_req_addr;
            end
            hs = wdata_valid && wdata_ready;
            if (dpi_wr_valid !== hs) ob_wr_bad++;
            if (hs) begin
                if (dpi_wr_bits !== mdata(x_addr, x_salt, x_wr_idx)) ob_wr_bad++;
                ob_wr_hs++; ob_last_wr_cycle = x_cyc; x_wr_idx++;
            end
            if (dpi_rd_valid && dpi_rd_ready) x_mem_idx++;
            if (x_cyc == x_hold - 1) begin ob_stall_push = x_mem_idx; ob_stall_ready = dpi_rd_ready; end
            if (rdata_valid && rdata_ready) begin
                if (ob_rd_pops > x_len || rdata_bits !== mdata(x_addr, x_salt, ob_rd_pops)
                    || rdata_last !== (ob_rd_pops == x_len)) ob_rd_bad++;
                if (rdata_last === 1'b1) ob_last_cnt++;
                if (ob_rd_pops == x_len) ob_last_pop_cycle = x_cyc;
                ob_rd_pops++;
            end
            if (done) begin ob_done_cycles++; if (!done_seen) ob_done_cycle = x_cyc; end
            if (done_seen) begin fin = 1; ob_post_ready = cmd_ready; end
            else if (done) done_seen = 1;
            x_cyc++;
            if (x_cyc >= BUDGET && !fin) begin ob_timeout = 1; fin = 1; end
            @(posedge clock); #1;
            if (accepted) cmd_valid = 1'b0;
            drive_step();
        end
        drive_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        wdata_valid = 1'b1; wdata_bits = {$urandom, $urandom}; dpi_rd_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0; drive_idle();
        @(negedge clock);
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_checks++; if (rdata_valid !== 1'b0) $display("FAIL reset_rdata_valid: got %b want 0", rdata_valid); else n_pass++;
        n_checks++; if ({dpi_req_valid, dpi_wr_valid, wdata_ready, dpi_rd_ready} !== 4'b0)
            $display("FAIL reset_strobes: got %b want 0000", {dpi_req_valid, dpi_wr_valid, wdata_ready, dpi_rd_ready}); else n_pass++;
        n_checks++; if ({dpi_req_opcode, dpi_req_len, dpi_req_addr, dpi_wr_bits} !== '0)
            $display("FAIL reset_dpi_fields: got %h/%h/%h/%h want 0", dpi_req_opcode, dpi_req_len, dpi_req_addr, dpi_wr_bits); else n_pass++;
`ifdef VME_DPI_ADAPTER_STATS_EN
        n_checks++; if ({stat_rd_beats, stat_wr_beats} !== 64'd0)
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_rd_beats, stat_wr_beats); else n_pass++;
`endif
        @(posedge clock); #1;
    endtask

    task automatic test_write_basic();
        do_xfer(1, 64'h1000, 3, 60, 0, 0, 0, -1);
        n_checks++; if (ob_timeout !== 0) $display("FAIL wr_timeout: got %0d want 0", ob_timeout); else n_pass++;
        n_checks++; if (ob_req_pulses !== 1) $display("FAIL wr_req_pulses: got %0d want 1", ob_req_pulses); else n_pass++;
        n_checks++; if ({ob_req_opc, ob_req_len, ob_req_addr} !== {1'b1, 8'd3, 64'h1000})
            $display("FAIL wr_req_fields: got %b/%0d/%h want 1/3/1000", ob_req_opc, ob_req_len, ob_req_addr); else n_pass++;
        n_checks++; if (ob_wr_hs !== 4) $display("FAIL wr_beats: got %0d want 4", ob_wr_hs); else n_pass++;
        n_checks++; if (ob_wr_bad !== 0) $display("FAIL wr_dpi_beats: got %0d bad want 0", ob_wr_bad); else n_pass++;
        n_checks++; if (ob_done_cycle - ob_last_wr_cycle !== 1)
            $display("FAIL wr_done_latency: got %0d want 1", ob_done_cycle - ob_last_wr_cycle); else n_pass++;
        n_checks++; if (ob_done_cycles !== 1 || ob_post_ready !== 1'b1)
            $display("FAIL wr_done_pulse: got %0d cycles ready_after=%b want 1/1", ob_done_cycles, ob_post_ready); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL wr_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_read_len0();
        do_xfer(0, 64'h2000, 0, 0, 100, 100, 0, -1);
        n_checks++; if (ob_timeout !== 0) $display("FAIL rd0_timeout: got %0d want 0", ob_timeout); else n_pass++;
        n_checks++; if ({ob_req_opc, ob_req_len, ob_req_addr} !== {1'b0, 8'd0, 64'h2000})
            $display("FAIL rd0_req_fields: got %b/%0d/%h want 0/0/2000", ob_req_opc, ob_req_len, ob_req_addr); else n_pass++;
        n_checks++; if (ob_rd_pops !== 1 || ob_rd_bad !== 0 || ob_last_cnt !== 1)
            $display("FAIL rd0_beats: got pops=%0d bad=%0d last=%0d want 1/0/1", ob_rd_pops, ob_rd_bad, ob_last_cnt); else n_pass++;
        n_checks++; if (ob_done_cycle - ob_last_pop_cycle !== 1 || ob_done_cycles !== 1)
            $display("FAIL rd0_done: got latency=%0d cycles=%0d want 1/1", ob_done_cycle - ob_last_pop_cycle, ob_done_cycles); else n_pass++;
    endtask

    task automatic test_read_backpressure();
        do_xfer(0, {$urandom, $urandom}, 7, 0, 100, 100, 12, -1);
        n_checks++; if (ob_stall_push !== 2 || ob_stall_ready !== 1'b0)
            $display("FAIL bp_stall: got captured=%0d ready=%b want 2/0", ob_stall_push, ob_stall_ready); else n_pass++;
        n_checks++; if (ob_timeout !== 0 || ob_rd_pops !== 8 || ob_rd_bad !== 0 || ob_last_cnt !== 1)
            $display("FAIL bp_beats: got to=%0d pops=%0d bad=%0d last=%0d want 0/8/0/1", ob_timeout, ob_rd_pops, ob_rd_bad, ob_last_cnt); else n_pass++;
    endtask

    task automatic test_read_long();
`ifdef VME_DPI_ADAPTER_STATS_EN
        logic [31:0] before;
        before = stat_rd_beats;
`endif
        do_xfer(0, {$urandom, $urandom}, 255, 0, 70, 80, 0, -1);
        n_checks++; if (ob_timeout !== 0 || ob_rd_pops !== 256 || ob_rd_bad !== 0)
            $display("FAIL long_beats: got to=%0d pops=%0d bad=%0d want 0/256/0", ob_timeout, ob_rd_pops, ob_rd_bad); else n_pass++;
        n_checks++; if (ob_last_cnt !== 1) $display("FAIL long_last: got %0d want 1", ob_last_cnt); else n_pass++;
`ifdef VME_DPI_ADAPTER_STATS_EN
        n_checks++; if (stat_rd_beats - before !== 32'd256)
            $display("FAIL long_stat_rd: got %0d want 256", stat_rd_beats - before); else n_pass++;
`endif
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            bit wr;
            int len, exp_wr, exp_rd;
            wr  = $urandom_range(1);
            len = $urandom_range(15);
            exp_wr = wr ? len + 1 : 0;
            exp_rd = wr ? 0 : len + 1;
            do_xfer(wr, {$urandom, $urandom}, len, $urandom_range(90, 30), $urandom_range(90, 30),
                    $urandom_range(90, 30), $urandom_range(6), -1);
            n_checks++; if (ob_timeout !== 0 || ob_req_pulses !== 1 || ob_req_opc !== wr || ob_req_len !== LB'(len))
                $display("FAIL rand%0d_req: got to=%0d pulses=%0d opc=%b len=%0d want 0/1/%b/%0d", t, ob_timeout, ob_req_pulses, ob_req_opc, ob_req_len, wr, len); else n_pass++;
            n_checks++; if (ob_wr_hs !== exp_wr || ob_wr_bad !== 0 || ob_rd_pops !== exp_rd || ob_rd_bad !== 0)
                $display("FAIL rand%0d_beats: got wr=%0d wbad=%0d rd=%0d rbad=%0d want %0d/0/%0d/0", t, ob_wr_hs, ob_wr_bad, ob_rd_pops, ob_rd_bad, exp_wr, exp_rd); else n_pass++;
            n_checks++; if (ob_done_cycles !== 1 || ob_post_ready !== 1'b1 || err !== 1'b0)
                $display("FAIL rand%0d_end: got done=%0d ready=%b err=%b want 1/1/0", t, ob_done_cycles, ob_post_ready, err); else n_pass++;
        end
    endtask

    task automatic test_err_sticky();
        n_checks++; if (err !== 1'b0) $display("FAIL err_pre: got %b want 0", err); else n_pass++;
        do_xfer(1, 64'h3000, 1, 80, 0, 0, 0, 0);
        n_checks++; if (ob_timeout !== 0 || ob_wr_hs !== 2 || ob_done_cycles !== 1)
            $display("FAIL err_xfer: got to=%0d beats=%0d done=%0d want 0/2/1", ob_timeout, ob_wr_hs, ob_done_cycles); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else n_pass++;
        do_xfer(0, 64'h4000, 2, 0, 80, 80, 0, -1);
        n_checks++; if (ob_rd_pops !== 3 || ob_rd_bad !== 0) $display("FAIL err_next_cmd: got pops=%0d bad=%0d want 3/0", ob_rd_pops, ob_rd_bad); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int  captured, cyc;
        bit  accepted;
        captured = 0; cyc = 0; accepted = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h5000; cmd_len = 8'd5;
        dpi_rd_valid = 1'b1; dpi_rd_bits = {$urandom, $urandom}; rdata_ready = 1'b0;
        while (captured < 2 && cyc < 50) begin
            @(negedge clock);
            if (cmd_valid && cmd_ready) accepted = 1;
            if (dpi_rd_valid && dpi_rd_ready) captured++;
            cyc++;
            @(posedge clock); #1;
            if (accepted) cmd_valid = 1'b0;
        end
        n_checks++; if (captured !== 2) $display("FAIL rst_mid_reach: got %0d captured want 2", captured); else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (dpi_rd_ready !== 1'b0) $display("FAIL rst_mid_no_traffic: got %b want 0", dpi_rd_ready); else n_pass++;
        @(posedge clock); #1;
        @(negedge clock);
        n_checks++; if ({cmd_ready, rdata_valid, dpi_rd_ready, err, done, dpi_req_valid, dpi_wr_valid} !== 7'b1000000)
            $display("FAIL rst_mid_outputs: got %b want 1000000", {cmd_ready, rdata_valid, dpi_rd_ready, err, done, dpi_req_valid, dpi_wr_valid}); else n_pass++;
        n_checks++; if ({dpi_req_len, dpi_req_addr} !== '0) $display("FAIL rst_mid_req_fields: got %h/%h want 0", dpi_req_len, dpi_req_addr); else n_pass++;
`ifdef VME_DPI_ADAPTER_STATS_EN
        n_checks++; if ({stat_rd_beats, stat_wr_beats} !== 64'd0)
            $display("FAIL rst_mid_stats: got %0d/%0d want 0/0", stat_rd_beats, stat_wr_beats); else n_pass++;
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        do_xfer(1, 64'h6000, 2, 70, 0, 0, 0, -1);
        n_checks++; if (ob_accept_cycle !== 0) $display("FAIL rst_mid_accept: got cycle %0d want 0", ob_accept_cycle); else n_pass++;
        n_checks++; if (ob_timeout !== 0 || ob_wr_hs !== 3 || ob_wr_bad !== 0 || ob_done_cycles !== 1 || err !== 1'b0)
            $display("FAIL rst_mid_after: got to=%0d beats=%0d bad=%0d done=%0d err=%b want 0/3/0/1/0", ob_timeout, ob_wr_hs, ob_wr_bad, ob_done_cycles, err); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_write_basic();
        test_read_len0();
        test_read_backpressure();
        test_read_long();
        test_random();
        test_err_sticky();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/vme_dpi_adapter.md
VME_DPI_ADAPTER -- requirements
Module: vme_dpi_adapter

Interface
REQ-001 The block SHALL have parameter LEN_BITS, default 8, meaning burst length field width (beats-1).
REQ-002 The block SHALL have parameter ADDR_BITS, default 64, meaning byte address width.
REQ-003 The block SHALL have parameter DATA_BITS, default 64, meaning beat width.
REQ-004 The block SHALL have parameter RD_DEPTH, default 2, meaning read buffer entries (power of two, >=2).
REQ-005 Clock and reset SHALL be: clock, input, 1, clock; reset, input, 1, synchronous, active-high.
REQ-006 The command port SHALL be:
- cmd_valid, input, 1, command present.
- cmd_ready, output, 1, command accepted.
- cmd_write, input, 1, 1=write, 0=read.
- cmd_addr, input, ADDR_BITS, start address.
- cmd_len, input, LEN_BITS, beats-1.
REQ-007 The write data port SHALL be: wdata_valid, input, 1; wdata_ready, output, 1; wdata_bits, input, DATA_BITS; wdata_last, input, 1.
REQ-008 The read data port SHALL be: rdata_valid, output, 1; rdata_ready, input, 1; rdata_bits, output, DATA_BITS; rdata_last, output, 1.
REQ-009 Status outputs SHALL be: done, output, 1, one-cycle completion pulse; err, output, 1, sticky wdata_last mismatch.
REQ-010 The memory-model side SHALL be:
- dpi_req_valid, output, 1.
- dpi_req_opcode, output, 1.
- dpi_req_len, output, LEN_BITS.
- dpi_req_addr, output, ADDR_BITS.
- dpi_wr_valid, output, 1.
- dpi_wr_bits, output, DATA_BITS.
- dpi_rd_valid, input, 1.
- dpi_rd_bits, input, DATA_BITS.
- dpi_rd_ready, output, 1.

Function
REQ-011 The FSM SHALL have states IDLE, REQ, WR, RD and DONE.
REQ-012 In IDLE, cmd_ready SHALL be 1; on cmd_valid&&cmd_ready, the block SHALL register write/addr/len and go to REQ.
REQ-013 In REQ, dpi_req_valid SHALL be 1 for exactly one cycle with the registered opcode/len/addr; the next state SHALL be WR if write, else RD.
REQ-014 In WR, wdata_ready SHALL be 1; each wdata handshake SHALL drive dpi_wr_valid=1 and dpi_wr_bits=wdata_bits in the same cycle, combinationally, and increment the beat counter.
REQ-015 On beat len+1 of a write, the block SHALL go to DONE; if wdata_last differs from (beat==len), err SHALL set and stay set until reset.
REQ-016 In RD, dpi_rd_ready SHALL equal "buffer not full"; a beat SHALL be captured only when dpi_rd_valid&&dpi_rd_ready; beats offered while dpi_rd_ready=0 SHALL be ignored.
REQ-017 The read buffer SHALL be a FIFO: rdata_valid=not empty; pop on rdata_valid&&rdata_ready; simultaneous push and pop at full or empty SHALL be legal and SHALL keep the count unchanged.
REQ-018 rdata_last SHALL be 1 on the beat whose index equals len; the FSM SHALL leave RD for DONE once that beat is popped.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE; cmd_ready SHALL be 0 in every state except IDLE.
REQ-020 The beat counter SHALL be LEN_BITS+1 wide, so len=all-ones gives 2^LEN_BITS beats without wrap.
REQ-021 Outside their states, dpi_req_valid, dpi_wr_valid, wdata_ready and dpi_rd_ready SHALL be 0.

Reset
REQ-022 On reset: state=IDLE; FIFO flushed; counters=0; err=0; done=0; all valid outputs=0; dpi_req_* and dpi_wr_bits=0.
REQ-023 Reset mid-burst SHALL abandon the burst with no further DPI traffic and accept a new command in the first cycle after reset deasserts.

Configuration
REQ-024 With VME_DPI_ADAPTER_STATS_EN defined, the block SHALL add 32-bit outputs stat_rd_beats and stat_wr_beats, counting DPI beats, wrapping at 2^32 and cleared by reset; without it, these ports and counters SHALL NOT exist.

Structure
REQ-025 Package vme_dpi_pkg SHALL hold the state enum and OPC_RD=0/OPC_WR=1 constants.
REQ-026 The read buffer SHALL be the sub-module vme_rd_fifo, parameterised by DATA_BITS+1 and RD_DEPTH.

Verification
REQ-027 Write at addr 0x1000, len 3, with 4 beats -> one req pulse (opcode 1, len 3), 4 dpi_wr_valid pulses, done 1 cycle after the 4th beat, err=0.
REQ-028 Read at 0x2000, len 0, rdata_ready=1 -> one beat with rdata_last=1, then done.
REQ-029 Read len 7 with rdata_ready held 0 -> dpi_rd_ready drops after 2 beats; release -> 8 beats in order, no loss or duplication.
REQ-030 Write len 1 with wdata_last=1 on beat 0 -> err=1 and stays 1 across the next command.
REQ-031 Reset asserted at beat 2 of a len-5 read -> outputs at reset values; a new command is accepted the next cycle.
REQ-032 Read len 255 -> 256 beats, rdata_last on the 256th only; with STATS_EN, stat_rd_beats=256.
